// File: rtl/wb_debug_master.sv
// wb_debug_master: serial-byte-driven Wishbone initiator for host peek/poke.
// Parses 'R'/'W' packets from a UART receiver, runs one 32-bit classic
// Wishbone cycle, and streams status/read data back to a UART transmitter.
// Optional feature macro: WBDBG_TIMEOUT_EN enables the ack timeout and the
// NAK-on-timeout reply; without it the bus phase waits for ack forever.
module wb_debug_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // Wishbone initiator
  output logic [31:0] adr,
  output logic        cyc,
  output logic        stb,
  output logic        we,
  output logic [3:0]  sel,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack,
  input  logic        stall,
  // byte stream in/out
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  // status
  output logic        busy,
  output logic        dropped
);

  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // Out-of-range TIMEOUT is a configuration error regardless of the build.
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_debug_master: TIMEOUT must be in 2..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  byte_cnt;    // position within the 4-byte address/data field
  logic        is_wr;       // packet is a write
  logic        stb_done;    // slave has accepted stb this cycle
  logic        resp_ok;     // reply starts with ACK (else NAK only)
  logic [2:0]  resp_cnt;    // reply byte being presented
  logic [2:0]  resp_last;   // index of final reply byte (0 or 4)
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rd_q;
  logic        tmo_hit;     // ack wait expires this cycle
  logic        cmd_ok;

  assign cmd_ok = (rx_data == CMD_RD) || (rx_data == CMD_WR);
  assign adr    = adr_q;
  assign dat_o  = dat_q;

`ifdef WBDBG_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Counts BUS cycles; held at zero elsewhere so it is clear on BUS entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                tmo_cnt <= '0;
    else if (state == S_BUS)  tmo_cnt <= tmo_cnt + 16'd1;
    else                      tmo_cnt <= '0;
  end

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and bus/stream outputs. Bus strobes decode from state so an
  // asynchronous reset removes cyc/stb in the same cycle.
  always_comb begin
    state_nx = state;
    cyc      = 1'b0;
    stb      = 1'b0;
    we       = 1'b0;
    sel      = 4'h0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != S_IDLE);
    dropped  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_valid) state_nx = cmd_ok ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (rx_valid && byte_cnt == 2'd3) state_nx = is_wr ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (rx_valid && byte_cnt == 2'd3) state_nx = S_BUS;
      end
      S_BUS: begin
        cyc     = 1'b1;
        stb     = !stb_done;
        we      = is_wr;
        sel     = 4'hF;
        dropped = rx_valid;
        // ack checked first: an ack in the expiry cycle is a normal completion
        if (ack || tmo_hit) state_nx = S_RESP;
      end
      S_RESP: begin
        tx_valid = 1'b1;
        dropped  = rx_valid;
        case (resp_cnt)
          3'd0:    tx_data = resp_ok ? RSP_ACK : RSP_NAK;
          3'd1:    tx_data = rd_q[31:24];
          3'd2:    tx_data = rd_q[23:16];
          3'd3:    tx_data = rd_q[15:8];
          3'd4:    tx_data = rd_q[7:0];
          default: tx_data = 8'h00;
        endcase
        if (tx_ready && resp_cnt == resp_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Packet datapath: field shifting, bus handshake tracking, reply setup.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt  <= '0;
      is_wr     <= 1'b0;
      stb_done  <= 1'b0;
      resp_ok   <= 1'b0;
      resp_cnt  <= '0;
      resp_last <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rd_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          stb_done <= 1'b0;
          if (rx_valid) begin
            is_wr    <= (rx_data == CMD_WR);
            byte_cnt <= '0;
            resp_cnt <= '0;
            if (!cmd_ok) begin
              resp_ok   <= 1'b0;
              resp_last <= 3'd0;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            adr_q    <= {adr_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            dat_q    <= {dat_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_BUS: begin
          resp_cnt <= '0;
          if (!stall) stb_done <= 1'b1;
          if (ack) begin
            if (!is_wr) rd_q <= dat_i;
            resp_ok   <= 1'b1;
            resp_last <= is_wr ? 3'd0 : 3'd4;
          end else if (tmo_hit) begin
            resp_ok   <= 1'b0;
            resp_last <= 3'd0;
          end
        end
        S_RESP: begin
          stb_done <= 1'b0;
          if (tx_ready) resp_cnt <= resp_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
